// File: rtl/rf_wb_scheduler_if.sv
// Writeback bundle between the execute/memory requesters, the issue stage and the scheduler.
// The scheduler takes the slave side; requesters and issue logic take the master side.
interface rf_wb_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [4:0]       req0_rd;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [4:0]       req1_rd;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             mark_valid;
    logic [4:0]       mark_rd;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rf_reg_write;
    logic [4:0]       rf_rd_addr;
    logic [WIDTH-1:0] rf_wr_data;

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        output mark_valid, mark_rd, rs1_addr, rs2_addr,
        input  req0_ready, req1_ready, rs1_busy, rs2_busy,
        input  rf_reg_write, rf_rd_addr, rf_wr_data
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        input  mark_valid, mark_rd, rs1_addr, rs2_addr,
        output req0_ready, req1_ready, rs1_busy, rs2_busy,
        output rf_reg_write, rf_rd_addr, rf_wr_data
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Shares the RF write port between ALU (req0) and load (req1) writebacks and keeps a busy scoreboard.
// Latency: 1 cycle accept -> rf_reg_write; rs*_busy combinational from flops, no bypass.
// Backpressure: loser sees ready low and holds; round-robin, or load-first under WB_LOAD_PRIORITY_EN.
module rf_wb_scheduler #(
    parameter int WIDTH  = 32,
    parameter int N_REGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    rf_wb_scheduler_if.slave wb
);
    logic              grant0;
    logic              grant1;
    logic              acc0;
    logic              acc1;
    logic              wr_en_q;
    logic [4:0]        wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] busy_d;

`ifdef WB_LOAD_PRIORITY_EN
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (wb.req1_valid) begin
            grant1 = 1'b1;
        end else if (wb.req0_valid) begin
            grant0 = 1'b1;
        end
    end
`else
    // last_grant: 0 = req0 won the previous accept, 1 = req1 did
    logic last_grant_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (wb.req0_valid && wb.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else if (wb.req0_valid) begin
            grant0 = 1'b1;
        end else if (wb.req1_valid) begin
            grant1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (acc0) begin
            last_grant_q <= 1'b0;
        end else if (acc1) begin
            last_grant_q <= 1'b1;
        end
    end
`endif

    assign acc0 = wb.req0_valid && grant0;
    assign acc1 = wb.req1_valid && grant1;

    assign wb.req0_ready = grant0;
    assign wb.req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (acc0) begin
            wr_en_q   <= (wb.req0_rd != 5'd0);
            wr_addr_q <= wb.req0_rd;
            wr_data_q <= wb.req0_data;
        end else if (acc1) begin
            wr_en_q   <= (wb.req1_rd != 5'd0);
            wr_addr_q <= wb.req1_rd;
            wr_data_q <= wb.req1_data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign wb.rf_reg_write = wr_en_q;
    assign wb.rf_rd_addr   = wr_addr_q;
    assign wb.rf_wr_data   = wr_data_q;

    // Clear is applied before mark so a new producer of the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (wb.mark_valid && (wb.mark_rd != 5'd0)) begin
            busy_d[wb.mark_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb.rs1_busy = busy_q[wb.rs1_addr];
    assign wb.rs2_busy = busy_q[wb.rs2_addr];

    a_one_ready: assert property (@(posedge clk) !(wb.req0_ready && wb.req1_ready));
    a_x0_idle:   assert property (@(posedge clk) disable iff (!reset) !busy_q[0]);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed table, hand sequences, and randomized traffic vs. a reference model.
// Inputs driven on the falling edge; combinational outputs checked 1ns later, registered outputs on the next falling edge.
module tb_rf_wb_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_wb_scheduler_if #(.WIDTH(32)) wb ();

    rf_wb_scheduler #(.WIDTH(32), .N_REGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         rst_n;
        bit         r0v;
        logic [4:0] r0rd;
        logic [31:0] r0d;
        bit         r1v;
        logic [4:0] r1rd;
        logic [31:0] r1d;
        bit         mv;
        logic [4:0] mrd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          e_r0;
        bit          e_r1;
        bit          e_b1;
        bit          e_b2;
        bit          e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    // Reference model: set of pending registers, last winner, and the write presented to the RF.
    bit          mdl_busy [32];
    int          mdl_last;
    bit          mdl_wr;
    logic [4:0]  mdl_addr;
    logic [31:0] mdl_data;
    bit          mdl_init = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int winner(input bit v0, input bit v1);
`ifdef WB_LOAD_PRIORITY_EN
        if (v1) return 1;
        if (v0) return 0;
        return -1;
`else
        if (v0 && v1) return 1 - mdl_last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
`endif
    endfunction

    function automatic stim_t st(input bit rst_n, input bit r0v, input logic [4:0] r0rd, input logic [31:0] r0d,
                                 input bit r1v, input logic [4:0] r1rd, input logic [31:0] r1d,
                                 input bit mv, input logic [4:0] mrd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s;
        s.rst_n = rst_n; s.r0v = r0v; s.r0rd = r0rd; s.r0d = r0d;
        s.r1v = r1v; s.r1rd = r1rd; s.r1d = r1d;
        s.mv = mv; s.mrd = mrd; s.rs1 = rs1; s.rs2 = rs2;
        return s;
    endfunction

    function automatic vec_t vv(input stim_t s, input bit r0, input bit r1, input bit b1, input bit b2,
                                input bit wr, input logic [4:0] addr, input logic [31:0] data);
        vec_t v;
        v.s = s; v.e_r0 = r0; v.e_r1 = r1; v.e_b1 = b1; v.e_b2 = b2;
        v.e_wr = wr; v.e_addr = addr; v.e_data = data;
        return v;
    endfunction

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step(input stim_t s, output bit rdy0, output bit rdy1, output bit b1, output bit b2);
        int g;
        reset         = s.rst_n;
        wb.req0_valid = s.r0v;  wb.req0_rd = s.r0rd;  wb.req0_data = s.r0d;
        wb.req1_valid = s.r1v;  wb.req1_rd = s.r1rd;  wb.req1_data = s.r1d;
        wb.mark_valid = s.mv;   wb.mark_rd = s.mrd;
        wb.rs1_addr   = s.rs1;  wb.rs2_addr = s.rs2;
        #1;
        rdy0 = wb.req0_ready; rdy1 = wb.req1_ready;
        b1 = wb.rs1_busy;     b2 = wb.rs2_busy;
        g = winner(s.r0v, s.r1v);
        if (mdl_init) begin
            check("model_req0_ready", rdy0, g == 0);
            check("model_req1_ready", rdy1, g == 1);
            check("model_rs1_busy", b1, mdl_busy[s.rs1]);
            check("model_rs2_busy", b2, mdl_busy[s.rs2]);
        end
        @(posedge clk);
        if (!s.rst_n) begin
            foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
            mdl_last = 1; mdl_wr = 1'b0; mdl_addr = '0; mdl_data = '0;
            mdl_init = 1'b1;
        end else if (mdl_init) begin
            if (mdl_wr) mdl_busy[mdl_addr] = 1'b0;
            if (s.mv && s.mrd != 0) mdl_busy[s.mrd] = 1'b1;
            if (g == 0) begin
                mdl_wr = (s.r0rd != 0); mdl_addr = s.r0rd; mdl_data = s.r0d; mdl_last = 0;
            end else if (g == 1) begin
                mdl_wr = (s.r1rd != 0); mdl_addr = s.r1rd; mdl_data = s.r1d; mdl_last = 1;
            end else begin
                mdl_wr = 1'b0;
            end
        end
        @(negedge clk);
        if (mdl_init) begin
            check("model_rf_reg_write", wb.rf_reg_write, mdl_wr);
            check("model_rf_rd_addr", wb.rf_rd_addr, mdl_addr);
            check("model_rf_wr_data", wb.rf_wr_data, mdl_data);
        end
    endtask

    stim_t idle;
    vec_t  tbl [12];
    bit    r0, r1, b1, b2;

    initial begin
        int exp_win [4];
        bit p0v, p1v;
        logic [4:0] p0rd, p1rd;
        logic [31:0] p0d, p1d;
        stim_t s;

        idle = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = vv(st(1, 0, 0, 0,            0, 0, 0,      1, 5, 5, 0), 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = vv(st(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 5, 5), 1, 0, 1, 1, 1, 5, 32'hDEADBEEF);
        tbl[2]  = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 5, 0), 0, 0, 1, 0, 0, 5, 32'hDEADBEEF);
        tbl[3]  = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 5, 0), 0, 0, 0, 0, 0, 5, 32'hDEADBEEF);
        tbl[4]  = vv(st(1, 0, 0, 0,            1, 0, 32'h1234, 1, 0, 0, 0), 0, 1, 0, 0, 0, 0, 32'h1234);
        tbl[5]  = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 0, 5), 0, 0, 0, 0, 0, 0, 32'h1234);
        tbl[6]  = vv(st(1, 0, 0, 0,            1, 7, 32'h77, 1, 7, 7, 7), 0, 1, 0, 0, 1, 7, 32'h77);
        tbl[7]  = vv(st(1, 0, 0, 0,            0, 0, 0,      1, 7, 7, 7), 0, 0, 1, 1, 0, 7, 32'h77);
        tbl[8]  = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0), 0, 0, 1, 0, 0, 7, 32'h77);
        tbl[9]  = vv(st(1, 1, 7, 32'h99,       0, 0, 0,      0, 0, 7, 7), 1, 0, 1, 1, 1, 7, 32'h99);
        tbl[10] = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0), 0, 0, 1, 0, 0, 7, 32'h99);
        tbl[11] = vv(st(1, 0, 0, 0,            0, 0, 0,      0, 0, 7, 0), 0, 0, 0, 0, 0, 7, 32'h99);

        step(idle, r0, r1, b1, b2);
        @(negedge clk);

        // Reset held two cycles with req0 requesting
        s = st(0, 1, 4, 32'hAAAA, 0, 0, 0, 0, 0, 0, 0);
        step(s, r0, r1, b1, b2);
        step(s, r0, r1, b1, b2);
        check("reset_rf_reg_write", wb.rf_reg_write, 0);
        check("reset_rf_rd_addr", wb.rf_rd_addr, 0);
        check("reset_rf_wr_data", wb.rf_wr_data, 0);
        wb.req0_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wb.rs1_addr = 5'(i); wb.rs2_addr = 5'(31 - i);
            #0.25;
            check("reset_rs1_busy", wb.rs1_busy, 0);
            check("reset_rs2_busy", wb.rs2_busy, 0);
        end
        @(negedge clk);

        // First contention after reset
        step(st(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), r0, r1, b1, b2);
`ifdef WB_LOAD_PRIORITY_EN
        check("first_grant_req1", r1, 1);
`else
        check("first_grant_req0", r0, 1);
`endif

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, r0, r1, b1, b2);
            check($sformatf("tbl%0d_req0_ready", i), r0, tbl[i].e_r0);
            check($sformatf("tbl%0d_req1_ready", i), r1, tbl[i].e_r1);
            check($sformatf("tbl%0d_rs1_busy", i), b1, tbl[i].e_b1);
            check($sformatf("tbl%0d_rs2_busy", i), b2, tbl[i].e_b2);
            check($sformatf("tbl%0d_rf_reg_write", i), wb.rf_reg_write, tbl[i].e_wr);
            check($sformatf("tbl%0d_rf_rd_addr", i), wb.rf_rd_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_rf_wr_data", i), wb.rf_wr_data, tbl[i].e_data);
        end

        // Continuous contention from a fresh reset
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), r0, r1, b1, b2);
`ifdef WB_LOAD_PRIORITY_EN
        exp_win = '{1, 1, 1, 1};
`else
        exp_win = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            step(st(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 1, 2), r0, r1, b1, b2);
            check($sformatf("cont%0d_req0_ready", i), r0, exp_win[i] == 0);
            check($sformatf("cont%0d_req1_ready", i), r1, exp_win[i] == 1);
            check($sformatf("cont%0d_rf_reg_write", i), wb.rf_reg_write, 1);
            check($sformatf("cont%0d_rf_rd_addr", i), wb.rf_rd_addr, exp_win[i] == 0 ? 5'd1 : 5'd2);
        end

        // Reset on the edge that accepts a write to x3
        step(st(1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0), r0, r1, b1, b2);
        step(st(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 0), r0, r1, b1, b2);
        check("midrst_busy_before", b1, 1);
        check("midrst_rf_reg_write", wb.rf_reg_write, 0);
        check("midrst_rf_rd_addr", wb.rf_rd_addr, 0);
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0), r0, r1, b1, b2);
        check("midrst_busy3", b1, 0);
        check("midrst_no_write", wb.rf_reg_write, 0);

        // Randomized traffic; requesters hold their request until accepted
        p0v = 0; p1v = 0; p0rd = 0; p1rd = 0; p0d = 0; p1d = 0;
        for (int c = 0; c < 600; c++) begin
            if (!p0v && $urandom_range(0, 2) != 0) begin
                p0v = 1; p0rd = 5'($urandom_range(0, 31)); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1; p1rd = 5'($urandom_range(0, 31)); p1d = $urandom;
            end
            s = st($urandom_range(0, 99) != 0, p0v, p0rd, p0d, p1v, p1rd, p1d,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step(s, r0, r1, b1, b2);
            if (r0) p0v = 0;
            if (r1) p1v = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
